// File: rtl/cnn_stage_sequencer.sv
// Sequences the four CNN stage-wait requests (Ti1..Ti4) into the stage delay timer.
// Each request is held until its To level is seen, then all requests rest for a fixed gap.
module cnn_stage_sequencer #(
  parameter int TIMEOUT_W  = 16,
  parameter int TIMEOUT    = 4095,
  parameter int GAP_CYCLES = 2
) (
  input  logic       S_AXIS_ACLK,
  input  logic       S_AXIS_ARESET,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] stage_en,
  input  logic       To1,
  input  logic       To2,
  input  logic       To3,
  input  logic       To4,
  output logic       Ti1,
  output logic       Ti2,
  output logic       Ti3,
  output logic       Ti4,
  output logic       busy,
  output logic [1:0] stage_idx,
  output logic       stage_done,
  output logic       done,
  output logic       timeout,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, RUN, GAP, FIN, ERR} state_t;

  state_t               state_q, state_d;
  logic [3:0]           mask_q, mask_d;
  logic [1:0]           stage_q, stage_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [7:0]           gap_q, gap_d;
  logic [3:0]           ti_q, ti_d;
  logic                 busy_q, busy_d;
  logic                 stage_done_q, stage_done_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 err_q, err_d;

  logic [3:0] to_vec;
  logic       to_cur;
  logic [1:0] first_stage;
  logic [1:0] next_stage;
  logic       more_stages;

  assign to_vec = {To4, To3, To2, To1};
  assign to_cur = to_vec[stage_q];

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    first_stage = 2'd0;
    next_stage  = 2'd0;
    more_stages = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (stage_en[i]) first_stage = 2'(i);
      if (mask_q[i] && (i > int'(stage_q))) begin
        next_stage  = 2'(i);
        more_stages = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    stage_d      = stage_q;
    wdog_d       = wdog_q;
    gap_d        = gap_q;
    err_d        = err_q;
    stage_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          mask_d  = stage_en;
          err_d   = 1'b0;
          stage_d = first_stage;
          wdog_d  = '0;
          state_d = (stage_en == 4'b0000) ? FIN : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (to_cur) begin
          stage_done_d = 1'b1;
          if (more_stages) begin
            state_d = GAP;
            gap_d   = 8'd0;
          end else begin
            state_d = FIN;
          end
        end else if (wdog_q == TIMEOUT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_q == 8'(GAP_CYCLES - 1)) begin
          state_d = RUN;
          stage_d = next_stage;
          wdog_d  = '0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the state being entered.
    done_d    = (state_d == FIN);
    timeout_d = (state_d == ERR);
    if (state_d == ERR) err_d = 1'b1;
    busy_d = (state_d == RUN) || (state_d == GAP);
    ti_d   = (state_d == RUN) ? (4'b0001 << stage_d) : 4'b0000;
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q      <= IDLE;
      mask_q       <= 4'b0000;
      stage_q      <= 2'd0;
      wdog_q       <= '0;
      gap_q        <= 8'd0;
      ti_q         <= 4'b0000;
      busy_q       <= 1'b0;
      stage_done_q <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      stage_q      <= stage_d;
      wdog_q       <= wdog_d;
      gap_q        <= gap_d;
      ti_q         <= ti_d;
      busy_q       <= busy_d;
      stage_done_q <= stage_done_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
    end
  end

  assign {Ti4, Ti3, Ti2, Ti1} = ti_q;
  assign busy       = busy_q;
  assign stage_idx  = stage_q;
  assign stage_done = stage_done_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Bench for cnn_stage_sequencer: a behavioural stage timer drives To*, and a timeline model
// built from per-stage thresholds predicts every output cycle by cycle.
module tb_cnn_stage_sequencer;

  localparam int TMO  = 300;
  localparam int GAP  = 2;
  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] stage_en = 4'b0000;
  logic       To1, To2, To3, To4;
  logic       Ti1, Ti2, Ti3, Ti4;
  logic       busy, stage_done, done, timeout, err;
  logic [1:0] stage_idx;

  int checks = 0;
  int failures = 0;
  int thr [4];
  int tcnt [4];
  bit err_now = 1'b0;

  logic [3:0] e_ti   [MAXC];
  bit         e_busy [MAXC];
  logic [1:0] e_idx  [MAXC];
  bit         e_sd   [MAXC];
  bit         e_done [MAXC];
  bit         e_to   [MAXC];
  bit         e_err  [MAXC];

  cnn_stage_sequencer #(.TIMEOUT_W(16), .TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .start(start), .abort(abort),
    .stage_en(stage_en), .To1(To1), .To2(To2), .To3(To3), .To4(To4),
    .Ti1(Ti1), .Ti2(Ti2), .Ti3(Ti3), .Ti4(Ti4), .busy(busy), .stage_idx(stage_idx),
    .stage_done(stage_done), .done(done), .timeout(timeout), .err(err)
  );

  always #5 clk = ~clk;

  // Stage timer: To_k rises once Ti_k has been high for thr[k] cycles, and clears when Ti_k drops.
  logic [3:0] ti_v;
  assign ti_v = {Ti4, Ti3, Ti2, Ti1};
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) tcnt[k] <= ti_v[k] ? tcnt[k] + 1 : 0;
  end
  assign To1 = Ti1 && (tcnt[0] >= thr[0]);
  assign To2 = Ti2 && (tcnt[1] >= thr[1]);
  assign To3 = Ti3 && (tcnt[2] >= thr[2]);
  assign To4 = Ti4 && (tcnt[3] >= thr[3]);

  task automatic checkOutput(input string tag, input int cyc, input logic [8:0] obs, input logic [8:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic setThr(input int a, input int b, input int c, input int d);
    thr[0] = a; thr[1] = b; thr[2] = c; thr[3] = d;
  endtask

  // Timeline with start sampled at cycle 0: stage k runs thr+1 cycles (or TMO on expiry),
  // stage_done follows, then GAP idle cycles before the next enabled stage.
  task automatic build_model(input logic [3:0] mask, output int last_ev);
    int t;
    bit stopped;
    for (int c = 0; c < MAXC; c++) begin
      e_ti[c] = 4'b0000; e_busy[c] = 1'b0; e_idx[c] = 2'd0; e_sd[c] = 1'b0;
      e_done[c] = 1'b0; e_to[c] = 1'b0; e_err[c] = (c == 0) ? err_now : 1'b0;
    end
    t = 1;
    stopped = 1'b0;
    last_ev = 1;
    if (mask == 4'b0000) e_done[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (mask[k] && !stopped) begin
        if (thr[k] >= TMO) begin
          for (int c = t; c < t + TMO; c++) begin
            e_ti[c][k] = 1'b1; e_busy[c] = 1'b1; e_idx[c] = 2'(k);
          end
          last_ev = t + TMO;
          e_to[last_ev] = 1'b1;
          for (int c = last_ev; c < MAXC; c++) e_err[c] = 1'b1;
          stopped = 1'b1;
        end else begin
          for (int c = t; c <= t + thr[k]; c++) begin
            e_ti[c][k] = 1'b1; e_busy[c] = 1'b1; e_idx[c] = 2'(k);
          end
          last_ev = t + thr[k] + 1;
          e_sd[last_ev] = 1'b1;
          if ((mask >> (k + 1)) != 4'b0000) begin
            for (int c = last_ev; c < last_ev + GAP; c++) begin
              e_busy[c] = 1'b1; e_idx[c] = 2'(k);
            end
            t = last_ev + GAP;
          end else begin
            e_done[last_ev] = 1'b1;
          end
        end
      end
    end
  endtask

  // abort_at: -1 none, -2 random point in the run; reset_at: -1 none.
  task automatic applyStimulus(input string name, input logic [3:0] mask, input int abort_in,
                               input int reset_at, input bit spurious);
    int last_ev, ncyc, abort_at;
    bit abort_eff, eb, kerr;
    logic [8:0] obs, expv;
    build_model(mask, last_ev);
    abort_at = abort_in;
    if (abort_at == -2) abort_at = int'($urandom_range(1, last_ev));
    abort_eff = (abort_at == 0) || (abort_at > 0 && e_busy[abort_at]);
    ncyc = last_ev + 4;
    if (abort_eff && abort_at + 6 < ncyc) ncyc = abort_at + 6;
    if (reset_at >= 0 && reset_at + 6 < ncyc) ncyc = reset_at + 6;
    kerr = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (reset_at >= 0 && c > reset_at) begin
        expv = 9'd0; eb = 1'b0;
      end else if (abort_eff && c > abort_at) begin
        expv = {8'd0, e_err[abort_at]}; eb = 1'b0;
      end else begin
        expv = {e_ti[c], e_busy[c], e_sd[c], e_done[c], e_to[c], e_err[c]};
        eb = e_busy[c];
      end
      kerr = expv[0];
      obs = {Ti4, Ti3, Ti2, Ti1, busy, stage_done, done, timeout, err};
      checkOutput({name, ".outs"}, c, obs, expv);
      if (eb) checkOutput({name, ".stage_idx"}, c, {7'd0, stage_idx}, {7'd0, e_idx[c]});
      start    = (c == 0) || (spurious && eb && $urandom_range(0, 3) == 0);
      stage_en = (c == 0) ? mask : 4'($urandom_range(0, 15));
      abort    = (c == abort_at);
      rst      = (c == reset_at);
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    err_now = kerr;
  endtask

  initial begin
    setThr(38, 15, 1, 285);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset.outs", 0, {Ti4, Ti3, Ti2, Ti1, busy, stage_done, done, timeout, err}, 9'd0);
    checkOutput("reset.stage_idx", 0, {7'd0, stage_idx}, 9'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("all_stages", 4'b1111, -1, -1, 1'b0);
    applyStimulus("mask_0101", 4'b0101, -1, -1, 1'b0);
    setThr(38, 15, 1, 100000);
    applyStimulus("watchdog", 4'b1000, -1, -1, 1'b0);
    setThr(38, 15, 1, 285);
    applyStimulus("err_clear_abort20", 4'b1111, 20, -1, 1'b0);
    applyStimulus("abort_with_start", 4'b1111, 0, -1, 1'b0);
    applyStimulus("empty_mask", 4'b0000, -1, -1, 1'b0);
    applyStimulus("busy_starts", 4'b1111, -1, -1, 1'b1);
    applyStimulus("reset_mid", 4'b1111, -1, 100, 1'b0);
    applyStimulus("restart", 4'b1111, -1, -1, 1'b0);
    setThr(TMO - 1, 0, 0, 0);
    applyStimulus("expiry_success", 4'b0001, -1, -1, 1'b0);
    setThr(TMO, 0, 0, 0);
    applyStimulus("expiry_timeout", 4'b0001, -1, -1, 1'b0);

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 4; k++)
        thr[k] = ($urandom_range(0, 9) == 0) ? TMO : int'($urandom_range(0, 40));
      applyStimulus("random", 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 2) == 0) ? -2 : -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnn_stage_sequencer.md
Name: cnn_stage_sequencer

Overview:
- Drives the four stage-wait requests (Ti1..Ti4) into the stage delay timer and consumes its done levels (To1..To4).
- On a start pulse it runs the enabled stages in order 1→4. Each request is held high until the matching To asserts, then dropped for a guaranteed gap so the timer counter clears.
- Reports per-stage completion, overall done, a watchdog timeout and abort.
- Sits between the CNN top-level control and the timer block.

Parameters:
- TIMEOUT_W, 16, width of the per-stage watchdog counter.
- TIMEOUT, 4095, maximum RUN cycles per stage before a timeout is declared. Must satisfy 2 ≤ TIMEOUT < 2^TIMEOUT_W.
- GAP_CYCLES, 2, cycles all Ti are held low between consecutive stages. Must be ≥1; 8-bit gap counter.

Ports:
- S_AXIS_ACLK  in  1  clock; all logic on the rising edge.
- S_AXIS_ARESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  level; cancels the sequence at the next edge.
- stage_en  in  4  stage enable mask, bit k-1 = stage k; latched on accepted start.
- To1, To2, To3, To4  in  1 each  timer done levels.
- Ti1, Ti2, Ti3, Ti4  out  1 each  timer requests; registered, at most one high at a time.
- busy  out  1  high while a sequence is active (RUN/GAP).
- stage_idx  out  2  current stage minus 1; valid while busy.
- stage_done  out  1  one-cycle pulse when a stage's To is observed.
- done  out  1  one-cycle pulse at sequence completion.
- timeout  out  1  one-cycle pulse on watchdog expiry.
- err  out  1  sticky timeout flag; cleared by reset or the next accepted start.

Behaviour:
- Reset (synchronous, applied at the clock edge): state=IDLE. Outputs Ti*=0, busy=0, stage_idx=0, stage_done=0, done=0, timeout=0, err=0. Mask, watchdog and gap counter are all cleared to 0.
- States: IDLE, RUN, GAP, FIN, ERR.
- IDLE:
  - start=1 and abort=0 → latch stage_en, clear err, select the lowest enabled stage.
  - Next state is RUN, or FIN if the mask is 0.
  - start while not IDLE is ignored.
- RUN(k):
  - Ti_k=1, other Ti=0, busy=1, stage_idx=k-1.
  - Watchdog is 0 in the first RUN cycle and increments each RUN cycle.
  - Only To_k is examined; the other To inputs are ignored.
  - To_k=1 → next cycle: Ti_k=0 and stage_done=1. Go to GAP if a higher enabled stage remains, else FIN.
  - Latency: To_k is sampled in the cycle it is seen, so Ti_k is high exactly (timer threshold + 1) cycles.
  - Watchdog == TIMEOUT-1 with To_k=0 → ERR.
  - To_k=1 in the expiry cycle counts as success, not timeout.
- GAP:
  - All Ti=0, busy=1, stage_idx holds the finished stage.
  - Lasts exactly GAP_CYCLES cycles, then RUN(next enabled stage) with the watchdog reset to 0.
- FIN: one cycle; done=1, busy=0, all Ti=0; then IDLE.
- ERR: one cycle; timeout=1, err←1, busy=0, all Ti=0; then IDLE.
- Abort: abort=1 in RUN/GAP → next cycle is IDLE with all Ti=0 and busy=0.
  - No stage_done, done or timeout is issued.
  - Abort has priority over To_k and over watchdog expiry in the same cycle.
  - In IDLE, abort has priority over start (start is dropped).
- Reset mid-sequence: immediate return to the reset values at that edge; no pulses issued.
- Skipped (disabled) stages never assert their Ti and produce no stage_done.
- Pulses (stage_done, done, timeout) are exactly one cycle wide and never overlap, except stage_done coincides with done on the last stage.

Test Plan:
1. Behavioural timer (thresholds 38/15/1/285), stage_en=4'b1111, GAP_CYCLES=2, start at cycle 0:
   - Ti1 high cycles 1–39, Ti2 42–57, Ti3 60–61, Ti4 64–349.
   - stage_done at 40, 58, 62, 350; done=1 and busy=0 at 350.
   - Never two Ti high at once.
2. stage_en=4'b0101, same timer:
   - Only Ti1 (1–39) and Ti3 (42–43) assert.
   - done at cycle 44; Ti2 and Ti4 stay 0.
3. TIMEOUT=64, stage_en=4'b1000, To4 tied 0:
   - Ti4 high cycles 1–64.
   - timeout=1 at cycle 65, err=1 from 65 on, no done.
   - A new start clears err in the next cycle.
4. Abort at cycle 20 during stage 1:
   - Ti1 low and busy=0 at cycle 21; no stage_done or done.
   - Abort and start asserted together in IDLE → no Ti asserted.
5. stage_en=0 → done=1 at cycle 1, no Ti. Start pulses during busy are ignored (timeline identical to scenario 1).
6. Reset asserted at cycle 100 of scenario 1 → all outputs 0 at cycle 101; a restart behaves exactly as scenario 1.
